// File: rtl/pu_msp430_gpio_port_if.sv
// Peripheral bus between the CPU-side master and the GPIO port register block.
interface pu_msp430_gpio_port_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/pu_msp430_gpio_port.sv
// 8-pin GPIO port: memory-mapped POUT/PIN/PDIR/PIFG/PIES/PIE/PSEL registers,
// 2-flop pad synchronizer, armed edge detector and level interrupt request.
module pu_msp430_gpio_port #(
  parameter logic [14:0] BASE_ADDR = 15'h0020
) (
  input  logic       mclk,
  input  logic       puc_rst_n,
  pu_msp430_gpio_port_if.slave per,
  input  logic [7:0] p_din,
  output logic [7:0] p_dout,
  output logic [7:0] p_dout_en,
  output logic [7:0] p_sel,
  output logic       irq_port
);

  // Register state
  logic [7:0] r_pout, r_pdir, r_pifg, r_pies, r_pie, r_psel;
  logic [7:0] r_sync, r_pin, r_pin_d;
  logic [1:0] r_arm;

  // Decode
  logic       w_hit, w_wr, w_rd;
  logic [1:0] w_off;
  logic [3:0] w_wsel;
  logic       w_armed;
  logic [7:0] w_rise, w_fall, w_edge, w_pifg_nxt;

  assign w_hit   = per.per_en && (per.per_addr[13:2] == BASE_ADDR[14:3]);
  assign w_off   = per.per_addr[1:0];
  assign w_wr    = w_hit && (per.per_we != 2'b00);
  assign w_rd    = w_hit && (per.per_we == 2'b00);
  assign w_armed = (r_arm == 2'd3);

  // One-hot word select for writes
  always_comb begin
    w_wsel = 4'b0000;
    if (w_wr) w_wsel[w_off] = 1'b1;
  end

  // Pad synchronizer, delayed copy for edge detection, and arming counter
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_sync  <= 8'h00;
      r_pin   <= 8'h00;
      r_pin_d <= 8'h00;
      r_arm   <= 2'd0;
    end else begin
      r_sync  <= p_din;
      r_pin   <= r_sync;
      r_pin_d <= r_pin;
      if (!w_armed) r_arm <= r_arm + 2'd1;
    end
  end

  // Edge detection is held off until the synchronizer and PIN_d hold real pad data
  assign w_rise = ~r_pin_d &  r_pin;
  assign w_fall =  r_pin_d & ~r_pin;
  assign w_edge = {8{w_armed}} & ((~r_pies & w_rise) | (r_pies & w_fall));

  // PIFG next state: software write first, hardware set ORed on top so it wins
  always_comb begin
    w_pifg_nxt = r_pifg;
    if (w_wsel[1] && per.per_we[1]) w_pifg_nxt = per.per_din[15:8];
    w_pifg_nxt = w_pifg_nxt | w_edge;
  end

  // Software-writable registers; PIN and the word-3 high byte have no storage
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_pout <= 8'h00;
      r_pdir <= 8'h00;
      r_pies <= 8'h00;
      r_pie  <= 8'h00;
      r_psel <= 8'h00;
    end else begin
      if (w_wsel[0] && per.per_we[1]) r_pout <= per.per_din[15:8];
      if (w_wsel[1] && per.per_we[0]) r_pdir <= per.per_din[7:0];
      if (w_wsel[2] && per.per_we[0]) r_pies <= per.per_din[7:0];
      if (w_wsel[2] && per.per_we[1]) r_pie  <= per.per_din[15:8];
      if (w_wsel[3] && per.per_we[0]) r_psel <= per.per_din[7:0];
    end
  end

  // Interrupt flag register
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) r_pifg <= 8'h00;
    else            r_pifg <= w_pifg_nxt;
  end

  // Combinational read mux, zero when not a hitting read
  always_comb begin
    per.per_dout = 16'h0000;
    if (w_rd) begin
      unique case (w_off)
        2'd0: per.per_dout = {r_pout, r_pin};
        2'd1: per.per_dout = {r_pifg, r_pdir};
        2'd2: per.per_dout = {r_pie, r_pies};
        2'd3: per.per_dout = {8'h00, r_psel};
      endcase
    end
  end

  assign p_dout    = r_pout;
  assign p_dout_en = r_pdir;
  assign p_sel     = r_psel;
  assign irq_port  = |(r_pifg & r_pie);

endmodule

// File: doc/pu_msp430_gpio_port.md
PU_MSP430_GPIO_PORT -- requirements
Module: pu_msp430_gpio_port

Interface
REQ-001 Parameter: BASE_ADDR, 15'h0020, byte base address of the 8-byte register window, 8-byte aligned.
REQ-002 mclk  input  1  system clock; all state on rising edge.
REQ-003 puc_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 per_addr  input  14  word address; window hit when per_addr[13:2] == BASE_ADDR[14:3].
REQ-005 per_din  input  16  write data.
REQ-006 per_en  input  1  access strobe.
REQ-007 per_we  input  2  byte write enables, [1] high byte, [0] low byte; 2'b00 means read.
REQ-008 per_dout  output  16  read data.
REQ-009 p_din  input  8  pad input values, one bit per I/O cell data_in, asynchronous to mclk.
REQ-010 p_dout  output  8  per-pin output value, drives I/O cell data_out.
REQ-011 p_dout_en  output  8  per-pin output enable, drives I/O cell data_out_en.
REQ-012 p_sel  output  8  per-pin peripheral-function select.
REQ-013 irq_port  output  1  port interrupt request.

Function
REQ-014 Register map, word offset = per_addr[1:0]: 0 = {POUT, PIN}; 1 = {PIFG, PDIR}; 2 = {PIE, PIES}; 3 = {8'h00, PSEL}. High byte is listed first.
REQ-015 Write: on a clock edge with per_en=1, window hit and per_we[i]=1, the addressed byte i SHALL load per_din byte i. Other bytes are unchanged.
REQ-016 PIN is read-only; writes to it and to offset-3 high byte SHALL be ignored.
REQ-017 Read: per_dout SHALL be the addressed word combinationally when per_en=1, per_we=2'b00 and the window hits; otherwise 16'h0000.
REQ-018 PIN SHALL be a 2-flop synchronizer of p_din: a p_din change before edge n is visible in PIN after edge n+1.
REQ-019 p_dout = POUT, p_dout_en = PDIR, p_sel = PSEL, direct register outputs.
REQ-020 Edge detector: PIN_d SHALL register PIN every cycle. Bit k detects a rising edge (PIN_d=0, PIN=1) when PIES[k]=0 and a falling edge when PIES[k]=1.
REQ-021 A detected edge SHALL set PIFG[k] on the following clock edge, independent of PIE[k]; pad-to-PIFG latency is 3 mclk edges.
REQ-022 PIFG bits are cleared only by software write of 0. A hardware set SHALL win over a simultaneous software clear of the same bit. Software may also set PIFG bits by writing 1.
REQ-023 Writing PIES SHALL NOT itself set PIFG.
REQ-024 Arming: a 2-bit counter SHALL count 0..3 after reset and saturate at 3. Edge detection SHALL be suppressed while the counter is <3, so the synchronizer fill never sets PIFG.
REQ-025 irq_port = |(PIFG & PIE), combinational from registers.
REQ-026 Edges on pins with PSEL=1 or PDIR=1 SHALL still be detected; no masking beyond PIE.

Reset
REQ-027 While puc_rst_n=0, the following SHALL be 0 immediately, independent of mclk: POUT, PDIR, PIFG, PIES, PIE, PSEL, synchronizer flops, PIN_d and the arming counter.
REQ-028 During reset, p_dout, p_dout_en, p_sel and irq_port SHALL be 0; per_dout SHALL follow REQ-017, which yields 0 because all registers are 0.
REQ-029 Reset asserted mid-operation SHALL discard pending edges. After release, the arming counter restarts per REQ-024.

Verification
REQ-030 Hold p_din=8'hFF through reset release -> PIFG stays 8'h00 and irq_port=0; PIN reads 8'hFF after 2 edges.
REQ-031 Write word 0 = 16'hA500 with per_we=2'b10, then write word 1 = 16'h000F with per_we=2'b01 -> p_dout=8'hA5, p_dout_en=8'h0F; reading word 0 returns {8'hA5, PIN}.
REQ-032 PIES=0, PIE=8'h01, p_din[0] 0->1 -> PIFG[0]=1 exactly 3 edges later and irq_port=1. Then write PIFG=0 -> irq_port=0 the next cycle.
REQ-033 PIES[3]=1, p_din[3] 1->0 -> PIFG[3]=1. A rising edge on the same pin -> no flag.
REQ-034 Software clear of PIFG[2] on the same edge that hardware sets PIFG[2] -> PIFG[2]=1.
REQ-035 Assert puc_rst_n=0 asynchronously mid-cycle with all registers nonzero -> all outputs are 0 before the next mclk edge.
